// File: rtl/ram_sxp_rd_pkg.sv
// Shared types for the RAM read-side streamer: output-buffer occupancy
// encoding and pointer-width helpers.
package ram_sxp_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [1:0] occ_count(input occ_e occ);
    case (occ)
      OCC_ONE: return 2'd1;
      OCC_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ram_sxp_rd_skid.sv
// Two-entry output buffer (head + skid) with the valid/ready handshake and
// the EMPTY/ONE/TWO occupancy state machine; all outputs are registered.
module ram_sxp_rd_skid
  import ram_sxp_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  fetch_i,
  input  logic [DATA_WIDTH-1:0] fetch_data_i,
  input  logic                  m_tready_i,
  output logic                  m_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output occ_e                  occ_o
);

  occ_e                  occ_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  tvalid_q;
  logic                  pop;

  assign pop = tvalid_q & m_tready_i;

  // The fetch is never issued in TWO, so TWO only has to handle pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      tvalid_q <= 1'b0;
    end else if (flush_i) begin
      occ_q    <= OCC_EMPTY;
      tvalid_q <= 1'b0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (fetch_i) begin
            head_q   <= fetch_data_i;
            occ_q    <= OCC_ONE;
            tvalid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          case ({fetch_i, pop})
            2'b11: head_q <= fetch_data_i;
            2'b10: begin
              skid_q <= fetch_data_i;
              occ_q  <= OCC_TWO;
            end
            2'b01: begin
              occ_q    <= OCC_EMPTY;
              tvalid_q <= 1'b0;
            end
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            head_q <= skid_q;
            occ_q  <= OCC_ONE;
          end
        end
        default: begin
          occ_q    <= OCC_EMPTY;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = head_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/ram_sxp_rd.sv
// Read side of a RAM FIFO: reader pointer, empty compare and a 2-entry output
// buffer. Define RAM_SXP_RD_LEVEL_EN to get a registered fill-level output.
module ram_sxp_rd
  import ram_sxp_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] rptr_d;
  logic             ram_empty;
  logic             fetch;
  occ_e             occ;

  assign ram_empty = (rptr_q == wptr);
  // Uses registered occupancy only, so m_tready never reaches the RAM address.
  assign fetch     = !ram_empty && (occ != OCC_TWO) && !flush;

  always_comb begin
    rptr_d = rptr_q;
    if (flush)      rptr_d = wptr;
    else if (fetch) rptr_d = rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rptr_q <= '0;
    else        rptr_q <= rptr_d;
  end

  assign raddr = rptr_q[ADDR_WIDTH-1:0];
  assign rptr  = rptr_q;

  ram_sxp_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .fetch_i      (fetch),
    .fetch_data_i (rdata),
    .m_tready_i   (m_tready),
    .m_tvalid_o   (m_tvalid),
    .m_tdata_o    (m_tdata),
    .occ_o        (occ)
  );

`ifdef RAM_SXP_RD_LEVEL_EN
  logic [1:0]       cnt_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             pop;

  assign pop = m_tvalid & m_tready;

  // Built from next-state pointer and occupancy so a flush reads 0 right away.
  always_comb begin
    cnt_d = 2'd0;
    if (!flush) cnt_d = occ_count(occ) + {1'b0, fetch} - {1'b0, pop};
    level_d = {1'b0, wptr - rptr_d} + LVL_W'(cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_ram_sxp_rd.sv
// Directed bench for ram_sxp_rd with a behavioural 32x6 RAM and writer model.
module tb_ram_sxp_rd;
  import ram_sxp_rd_pkg::*;

  localparam int DW = 6;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW:0]   wptr;
  logic          flush;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [AW:0]   rptr;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tready;
  logic [AW+1:0] level;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  ram_sxp_rd #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wptr     (wptr),
    .flush    (flush),
    .raddr    (raddr),
    .rdata    (rdata),
    .rptr     (rptr),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready),
    .level    (level)
  );

  task automatic write_word(input logic [DW-1:0] d);
    mem[wptr[AW-1:0]] = d;
    wptr = wptr + 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wptr = '0; flush = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b0 || rptr !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: tvalid=%b rptr=%0d, want 0/0", i, m_tvalid, rptr);
      end
    end
    n_cmp++;
    if (m_tdata !== '0 || level !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: tdata=%h level=%0d, want 0/0", m_tdata, level);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) write_word(DW'(i));
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(i)) begin
        n_err++;
        $display("FAIL stream_word%0d: tvalid=%b tdata=%h, want 1/%h", i, m_tvalid, m_tdata, i);
      end
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (rptr !== 7'd8 || m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: rptr=%0d tvalid=%b, want 8/0", rptr, m_tvalid);
    end
    $display("test_stream done");
  endtask

  task automatic test_back_pressure();
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) write_word(DW'(i));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== 6'h01) begin
        n_err++;
        $display("FAIL bp_hold cyc%0d: tvalid=%b tdata=%h, want 1/01", i, m_tvalid, m_tdata);
      end
    end
    n_cmp++;
    if (rptr !== 6'd10 || dut.u_skid.occ_q !== OCC_TWO) begin
      n_err++;
      $display("FAIL bp_full: rptr=%0d occ=%0d, want 10/%0d", rptr, dut.u_skid.occ_q, OCC_TWO);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    for (int v = 1; v <= 4; v++) begin
      if (v > 1) begin @(posedge clk); @(negedge clk); end
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(v)) begin
        n_err++;
        $display("FAIL bp_drain%0d: tvalid=%b tdata=%h, want 1/%h", v, m_tvalid, m_tdata, v);
      end
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0 || rptr !== 6'd12) begin
      n_err++;
      $display("FAIL bp_end: tvalid=%b rptr=%0d, want 0/12", m_tvalid, rptr);
    end
    $display("test_back_pressure done");
  endtask

  task automatic test_random_stream();
    int            sent = 0;
    int            rcvd = 0;
    int            cycles = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW:0]   prev_rptr;
    logic          saw_wrap = 1'b0;
    logic [AW:0]   diff;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    prev_rptr = rptr;
    while (rcvd < 100 && cycles < 3000) begin
      @(posedge clk); #1;
      m_tready = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        diff = wptr - rptr;
        if (sent < 100 && diff < 7'd32) begin
          d = DW'(sent * 7 + 1);
          exp_q.push_back(d);
          write_word(d);
          sent++;
        end
      end
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
          n_err++;
          $display("FAIL rnd_hold: tvalid=%b tdata=%h, want 1/%h", m_tvalid, m_tdata, prev_data);
        end
      end
      if (m_tvalid && m_tready) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (m_tdata !== exp) begin
          n_err++;
          $display("FAIL rnd_word%0d: tdata=%h, want %h", rcvd, m_tdata, exp);
        end
        rcvd++;
      end
`ifdef RAM_SXP_RD_LEVEL_EN
      n_cmp++;
      if (level > 8'd34) begin
        n_err++;
        $display("FAIL rnd_level: level=%0d, want <=34", level);
      end
`endif
      if (rptr < prev_rptr) saw_wrap = 1'b1;
      prev_rptr  = rptr;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
    n_cmp++;
    if (rcvd != 100) begin
      n_err++;
      $display("FAIL rnd_timeout: received=%0d, want 100", rcvd);
    end
    n_cmp++;
    if (!saw_wrap || rptr !== 6'd48) begin
      n_err++;
      $display("FAIL rnd_wrap: wrapped=%b rptr=%0d, want 1/48", saw_wrap, rptr);
    end
    m_tready = 1'b1;
    $display("test_random_stream done: %0d words", rcvd);
  endtask

  task automatic test_wrap_burst();
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) write_word(DW'(i + 10));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(i + 10)) begin
        n_err++;
        $display("FAIL wrap_word%0d: tvalid=%b tdata=%h, want 1/%h", i, m_tvalid, m_tdata, i + 10);
      end
    end
    n_cmp++;
    if (rptr !== 6'd4) begin
      n_err++;
      $display("FAIL wrap_rptr: rptr=%0d, want 4", rptr);
    end
    $display("test_wrap_burst done");
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(DW'(i + 33));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre: tvalid=%b, want 1", m_tvalid);
    end
    @(posedge clk); #1;
    flush = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0 || rptr !== wptr) begin
      n_err++;
      $display("FAIL flush_post: tvalid=%b rptr=%0d, want 0/%0d", m_tvalid, rptr, wptr);
    end
`ifdef RAM_SXP_RD_LEVEL_EN
    n_cmp++;
    if (level !== '0) begin
      n_err++;
      $display("FAIL flush_level: level=%0d, want 0", level);
    end
`endif
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: tvalid=%b, want 0", m_tvalid);
    end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(DW'(i + 50));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 6'd50) begin
      n_err++;
      $display("FAIL arst_pre: tvalid=%b tdata=%h, want 1/%h", m_tvalid, m_tdata, 6'd50);
    end
    #2;
    rst_n = 1'b0; wptr = '0;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || rptr !== '0 || level !== '0) begin
      n_err++;
      $display("FAIL arst_clear: tvalid=%b tdata=%h rptr=%0d level=%0d, want all 0",
               m_tvalid, m_tdata, rptr, level);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    write_word(6'h2A);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: tvalid=%b, want 0", m_tvalid);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 6'h2A || rptr !== 6'd1) begin
      n_err++;
      $display("FAIL latency_word: tvalid=%b tdata=%h rptr=%0d, want 1/2a/1", m_tvalid, m_tdata, rptr);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_random_stream();
    test_wrap_burst();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sxp_rd.md
RAM_SXP_RD -- requirements
Module: ram_sxp_rd

Interface
REQ-001 Parameter DATA_WIDTH, default 6, width of a stored word.
REQ-002 Parameter ADDR_WIDTH, default 5, RAM address width; depth is 2^ADDR_WIDTH.
REQ-003 clk  input  1  single clock, shared with the RAM write port.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 wptr  input  ADDR_WIDTH+1  writer pointer; the MSB is the wrap bit.
REQ-006 flush  input  1  synchronous discard of all unread data.
REQ-007 raddr  output  ADDR_WIDTH  read address to the RAM's asynchronous read port.
REQ-008 rdata  input  DATA_WIDTH  RAM read data, combinational from raddr.
REQ-009 rptr  output  ADDR_WIDTH+1  reader pointer returned to the writer for full detection.
REQ-010 m_tvalid  output  1  output word valid.
REQ-011 m_tdata  output  DATA_WIDTH  output word.
REQ-012 m_tready  input  1  downstream accept.
REQ-013 level  output  ADDR_WIDTH+2  unread words, counting RAM and output buffer.

Function
REQ-014 The RAM is empty when rptr equals wptr, across all ADDR_WIDTH+1 bits.
REQ-015 raddr shall always equal rptr[ADDR_WIDTH-1:0].
REQ-016 The block holds a 2-entry output buffer (head and skid) with occupancy states EMPTY, ONE, TWO.
REQ-017 A fetch occurs in a cycle when the RAM is not empty, occupancy is not TWO, and flush is low.
REQ-018 A fetch captures rdata into the buffer tail and increments rptr by 1 (mod 2^(ADDR_WIDTH+1)).
REQ-019 A pop occurs when m_tvalid and m_tready are both high; on a pop the skid entry moves to the head.
REQ-020 The fetch decision shall depend only on registered occupancy, never combinationally on m_tready.
REQ-021 State transitions:
  - EMPTY to ONE on fetch.
  - ONE to TWO on fetch without pop.
  - ONE to EMPTY on pop without fetch.
  - ONE stays ONE on fetch with pop.
  - TWO to ONE on pop.
REQ-022 m_tvalid shall be high exactly when occupancy is not EMPTY; m_tdata is the head entry.
REQ-023 Latency: a word written at cycle N (wptr updated at edge N) appears on m_tvalid at cycle N+1.
REQ-024 Sustained throughput is one word per cycle while m_tready stays high and the RAM is not empty.
REQ-025 m_tdata and m_tvalid shall hold stable while m_tvalid is high and m_tready is low.
REQ-026 Flush: on the next edge rptr loads wptr, occupancy goes to EMPTY and m_tvalid goes low.
REQ-027 A pop in the same cycle as flush is discarded; flush has priority over both fetch and pop.
REQ-028 rptr wrap from 2^(ADDR_WIDTH+1)-1 to 0 is seamless, with no bubble.

Reset
REQ-029 On rst_n low, asynchronously: rptr=0, occupancy EMPTY, m_tvalid=0, m_tdata=0, level=0.
REQ-030 Reset mid-stream drops all buffered words; the writer is responsible for resetting wptr to 0 in the same reset.

Configuration
REQ-031 With macro RAM_SXP_RD_LEVEL_EN defined, level shall be registered and equal to (wptr - rptr) + occupancy, updated every cycle.
REQ-032 With RAM_SXP_RD_LEVEL_EN undefined, level shall be tied to 0 and no level arithmetic is synthesized.

Structure
REQ-033 The shared package holds the occupancy state enum (EMPTY/ONE/TWO) and a pointer-width helper constant (ADDR_WIDTH+1).
REQ-034 The 2-entry output buffer shall be a sub-module named ram_sxp_rd_skid, carrying the valid/ready handshake and the occupancy state machine.
REQ-035 The top level contains the pointer logic, the empty compare, and the level logic.

Verification
REQ-036 Reset then idle with wptr=0: m_tvalid=0 and rptr=0 for 10 cycles.
REQ-037 ADDR_WIDTH=5; write 8 words 0x01..0x08, m_tready=1: m_tdata 0x01..0x08 on 8 consecutive cycles, then rptr=8.
REQ-038 4 words written, m_tready=0: occupancy reaches TWO, rptr=2, m_tdata stays 0x01; then m_tready=1 delivers 0x01..0x04 back-to-back.
REQ-039 Stream 100 words through a 32-deep RAM with random m_tready: output order is preserved, rptr wraps 63 to 0 without a bubble, and level never exceeds 34.
REQ-040 flush asserted with 5 words pending and m_tvalid=1: next cycle m_tvalid=0, rptr equals wptr, and (with LEVEL_EN) level=0.
REQ-041 rst_n pulsed low mid-stream: outputs clear asynchronously before the next clk edge.
